// File: rtl/rib_arb_2m1s.sv
// rib_arb_2m1s: two-master, one-slave RIB bus arbiter.
//   Master 0 is the IFU fetch port, master 1 the EXU LSU port. One requester is
//   forwarded to the shared slave port per address phase. An owner FIFO records
//   which master issued each accepted request, so that in-order slave responses
//   can be routed back to the right master.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mN_req/addr/wrcs/mask/wdata  master N address phase (N = 0,1)
//   o_mN_gnt                     master N address phase accepted
//   o_mN_rsp, o_mN_rdata         response valid / read data to master N
//   i_mN_rdy                     master N can accept its response
//   o_s_req/addr/wrcs/mask/wdata muxed slave address phase
//   i_s_gnt                      slave accepted the address phase
//   i_s_rsp, i_s_rdata           slave response valid / read data
//   o_s_rdy                      response accepted by the owning master
//   o_busy                       transactions outstanding or request pending
//   o_err                        response arrived with no outstanding owner
module rib_arb_2m1s #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned OST_DEPTH  = 2,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic              i_m0_wrcs,
  input  logic [DW/8-1:0]   i_m0_mask,
  input  logic [DW-1:0]     i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rsp,
  output logic [DW-1:0]     o_m0_rdata,
  input  logic              i_m0_rdy,
  input  logic              i_m1_req,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic              i_m1_wrcs,
  input  logic [DW/8-1:0]   i_m1_mask,
  input  logic [DW-1:0]     i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rsp,
  output logic [DW-1:0]     o_m1_rdata,
  input  logic              i_m1_rdy,
  output logic              o_s_req,
  output logic [AW-1:0]     o_s_addr,
  output logic              o_s_wrcs,
  output logic [DW/8-1:0]   o_s_mask,
  output logic [DW-1:0]     o_s_wdata,
  input  logic              i_s_gnt,
  input  logic              i_s_rsp,
  input  logic [DW-1:0]     i_s_rdata,
  output logic              o_s_rdy,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OST_DEPTH + 1);

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } lock_state_t;

  lock_state_t          lock_state;
  logic                 lock_sel;
  logic                 rr_last;
  logic [OST_DEPTH-1:0] owner_q;
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [CW-1:0]        count;

  logic arb_sel;
  logic sel;
  logic empty;
  logic full;
  logic head;
  logic handshake;
  logic pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OST_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(OST_DEPTH));
  assign head  = owner_q[rptr];

  always_comb begin
    arb_sel = i_m1_req;
    if (i_m0_req && i_m1_req) begin
      arb_sel = (FIXED_PRIO != 0) ? 1'b1 : ~rr_last;
    end
  end

  // A request stalled at the slave pins the selection until it is granted.
  assign sel = (lock_state == ARB_LOCKED) ? lock_sel : arb_sel;

  assign o_s_req   = (i_m0_req | i_m1_req) & ~full & ~i_rst;
  assign o_s_addr  = sel ? i_m1_addr  : i_m0_addr;
  assign o_s_wrcs  = sel ? i_m1_wrcs  : i_m0_wrcs;
  assign o_s_mask  = sel ? i_m1_mask  : i_m0_mask;
  assign o_s_wdata = sel ? i_m1_wdata : i_m0_wdata;

  assign handshake = o_s_req & i_s_gnt;
  assign o_m0_gnt  = handshake & ~sel;
  assign o_m1_gnt  = handshake & sel;

  assign o_s_rdy    = ~empty & ~i_rst & (head ? i_m1_rdy : i_m0_rdy);
  assign pop        = i_s_rsp & o_s_rdy;
  assign o_m0_rsp   = i_s_rsp & ~empty & ~i_rst & ~head;
  assign o_m1_rsp   = i_s_rsp & ~empty & ~i_rst & head;
  assign o_m0_rdata = i_s_rdata;
  assign o_m1_rdata = i_s_rdata;

  assign o_busy = (~empty | o_s_req) & ~i_rst;
  assign o_err  = i_s_rsp & empty & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_state <= ARB_OPEN;
      lock_sel   <= 1'b0;
      rr_last    <= 1'b1;
      owner_q    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      if (handshake) begin
        owner_q[wptr] <= sel;
        wptr          <= next_ptr(wptr);
        rr_last       <= sel;
        lock_state    <= ARB_OPEN;
      end else if (o_s_req) begin
        lock_state <= ARB_LOCKED;
        lock_sel   <= sel;
      end
      if (pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({handshake, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_arb_2m1s.sv
// Bench for rib_arb_2m1s. A round-robin instance and a fixed-priority instance
// share all inputs; expected response owners are queued at grant time and
// popped when the slave response is accepted.
module tb_rib_arb_2m1s;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_m0_req, i_m1_req;
  logic [AW-1:0] i_m0_addr, i_m1_addr;
  logic          i_m0_wrcs, i_m1_wrcs;
  logic [3:0]    i_m0_mask, i_m1_mask;
  logic [DW-1:0] i_m0_wdata, i_m1_wdata;
  logic          i_m0_rdy, i_m1_rdy;
  logic          i_s_gnt, i_s_rsp;
  logic [DW-1:0] i_s_rdata;

  logic          o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata;
  logic          o_s_req, o_s_wrcs, o_s_rdy, o_busy, o_err;
  logic [AW-1:0] o_s_addr;
  logic [3:0]    o_s_mask;
  logic [DW-1:0] o_s_wdata;

  logic          fp_m0_gnt, fp_m1_gnt, fp_m0_rsp, fp_m1_rsp;
  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
  logic          fp_s_req, fp_s_wrcs, fp_s_rdy, fp_busy, fp_err;
  logic [AW-1:0] fp_s_addr;
  logic [3:0]    fp_s_mask;
  logic [DW-1:0] fp_s_wdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          sb_q[$];

  localparam logic [AW-1:0] A0 = 32'h0000_1000;
  localparam logic [AW-1:0] A1 = 32'h8000_2000;

  always #5 i_clk = ~i_clk;

  rib_arb_2m1s #(.AW(AW), .DW(DW), .OST_DEPTH(2), .FIXED_PRIO(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wrcs(i_m0_wrcs), .i_m0_mask(i_m0_mask),
    .i_m0_wdata(i_m0_wdata), .o_m0_gnt(o_m0_gnt), .o_m0_rsp(o_m0_rsp), .o_m0_rdata(o_m0_rdata),
    .i_m0_rdy(i_m0_rdy),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wrcs(i_m1_wrcs), .i_m1_mask(i_m1_mask),
    .i_m1_wdata(i_m1_wdata), .o_m1_gnt(o_m1_gnt), .o_m1_rsp(o_m1_rsp), .o_m1_rdata(o_m1_rdata),
    .i_m1_rdy(i_m1_rdy),
    .o_s_req(o_s_req), .o_s_addr(o_s_addr), .o_s_wrcs(o_s_wrcs), .o_s_mask(o_s_mask),
    .o_s_wdata(o_s_wdata), .i_s_gnt(i_s_gnt), .i_s_rsp(i_s_rsp), .i_s_rdata(i_s_rdata),
    .o_s_rdy(o_s_rdy), .o_busy(o_busy), .o_err(o_err)
  );

  rib_arb_2m1s #(.AW(AW), .DW(DW), .OST_DEPTH(2), .FIXED_PRIO(1)) dut_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wrcs(i_m0_wrcs), .i_m0_mask(i_m0_mask),
    .i_m0_wdata(i_m0_wdata), .o_m0_gnt(fp_m0_gnt), .o_m0_rsp(fp_m0_rsp), .o_m0_rdata(fp_m0_rdata),
    .i_m0_rdy(i_m0_rdy),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wrcs(i_m1_wrcs), .i_m1_mask(i_m1_mask),
    .i_m1_wdata(i_m1_wdata), .o_m1_gnt(fp_m1_gnt), .o_m1_rsp(fp_m1_rsp), .o_m1_rdata(fp_m1_rdata),
    .i_m1_rdy(i_m1_rdy),
    .o_s_req(fp_s_req), .o_s_addr(fp_s_addr), .o_s_wrcs(fp_s_wrcs), .o_s_mask(fp_s_mask),
    .o_s_wdata(fp_s_wdata), .i_s_gnt(i_s_gnt), .i_s_rsp(i_s_rsp), .i_s_rdata(i_s_rdata),
    .o_s_rdy(fp_s_rdy), .o_busy(fp_busy), .o_err(fp_err)
  );

  task automatic idle();
    i_m0_req = 1'b0; i_m1_req = 1'b0; i_s_gnt = 1'b0; i_s_rsp = 1'b0;
    i_m0_rdy = 1'b1; i_m1_rdy = 1'b1; i_s_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    i_rst = 1'b1;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_m0_req = 1'b1; i_m1_req = 1'b1; i_s_gnt = 1'b1; i_s_rsp = 1'b1;
    next_cycle();
    #4;
    vectors++;
    if ({o_s_req, o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp, o_s_rdy, o_err, o_busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {o_s_req, o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp, o_s_rdy, o_err, o_busy}, 8'h00);
    end
    apply_reset();
  endtask

  task automatic test_single();
    bit exp_owner;
    // cycle 0: m0 alone, slave grants immediately
    i_m0_req = 1'b1; i_s_gnt = 1'b1;
    #4;
    vectors++;
    if (o_m0_gnt !== 1'b1 || o_m1_gnt !== 1'b0) begin
      miscompares++; $display("FAIL single_gnt got=%b%b exp=10", o_m0_gnt, o_m1_gnt);
    end
    vectors++;
    if (o_s_addr !== A0 || o_s_wrcs !== 1'b1 || o_s_mask !== 4'hF || o_s_wdata !== 32'h1111_0000) begin
      miscompares++; $display("FAIL single_mux got=%h/%b/%h/%h exp=%h/1/f/11110000",
                              o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata, A0);
    end
    if (o_m0_gnt === 1'b1) sb_q.push_back(1'b0);
    next_cycle();
    i_m0_req = 1'b0; i_s_gnt = 1'b0;
    #4;
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++; $display("FAIL single_busy got=%b exp=1", o_busy);
    end
    next_cycle();
    // cycle 2: response
    i_s_rsp = 1'b1; i_s_rdata = 32'hDEAD_BEEF; i_m0_rdy = 1'b1;
    #4;
    exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b1;
    vectors++;
    if (o_m0_rsp !== !exp_owner || o_m1_rsp !== exp_owner || o_m0_rdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL single_rsp got=%b%b data=%h exp=%b%b data=deadbeef",
                              o_m0_rsp, o_m1_rsp, o_m0_rdata, !exp_owner, exp_owner);
    end
    vectors++;
    if (o_s_rdy !== 1'b1) begin
      miscompares++; $display("FAIL single_rdy got=%b exp=1", o_s_rdy);
    end
    next_cycle();
    idle();
    #4;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++; $display("FAIL single_empty got=%b exp=0", o_busy);
    end
    next_cycle();
  endtask

  task automatic test_arbitration();
    bit rr_last = 1'b1;
    bit exp_win;
    bit exp_owner;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      i_m0_req = 1'b1; i_m1_req = 1'b1; i_s_gnt = 1'b1;
      i_s_rsp = (i > 0); i_s_rdata = 32'hA000_0000 + i;
      exp_win = ~rr_last;
      #4;
      vectors++;
      if (o_m0_gnt !== !exp_win || o_m1_gnt !== exp_win ||
          o_s_addr !== (exp_win ? A1 : A0) || o_s_wdata !== (exp_win ? 32'h2222_0000 : 32'h1111_0000)) begin
        miscompares++; $display("FAIL rr_gnt[%0d] got=%b%b addr=%h exp=%b%b", i,
                                o_m0_gnt, o_m1_gnt, o_s_addr, !exp_win, exp_win);
      end
      vectors++;
      if (fp_m1_gnt !== 1'b1 || fp_m0_gnt !== 1'b0) begin
        miscompares++; $display("FAIL fp_gnt[%0d] got=%b%b exp=01", i, fp_m0_gnt, fp_m1_gnt);
      end
      if (i > 0) begin
        exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : ~exp_win;
        vectors++;
        if (o_m0_rsp !== !exp_owner || o_m1_rsp !== exp_owner) begin
          miscompares++; $display("FAIL rr_rsp[%0d] got=%b%b exp=%b%b", i,
                                  o_m0_rsp, o_m1_rsp, !exp_owner, exp_owner);
        end
        vectors++;
        if (fp_m1_rsp !== 1'b1 || fp_m0_rsp !== 1'b0) begin
          miscompares++; $display("FAIL fp_rsp[%0d] got=%b%b exp=01", i, fp_m0_rsp, fp_m1_rsp);
        end
      end
      sb_q.push_back(exp_win);
      rr_last = exp_win;
      next_cycle();
    end
    // drain the final outstanding response
    i_m0_req = 1'b0; i_m1_req = 1'b0; i_s_gnt = 1'b0; i_s_rsp = 1'b1;
    #4;
    exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
    vectors++;
    if (o_m0_rsp !== !exp_owner || o_m1_rsp !== exp_owner) begin
      miscompares++; $display("FAIL rr_drain got=%b%b exp=%b%b", o_m0_rsp, o_m1_rsp, !exp_owner, exp_owner);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_lock();
    bit exp_owner;
    // rr_last is now 1, so an unlocked contention would pick m0
    i_m1_req = 1'b1; i_s_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) i_m0_req = 1'b1;
      #4;
      vectors++;
      if (o_s_req !== 1'b1 || o_s_addr !== A1 || o_m0_gnt !== 1'b0 || o_m1_gnt !== 1'b0) begin
        miscompares++; $display("FAIL lock_hold[%0d] got req=%b addr=%h gnt=%b%b exp req=1 addr=%h gnt=00",
                                c, o_s_req, o_s_addr, o_m0_gnt, o_m1_gnt, A1);
      end
      next_cycle();
    end
    i_s_gnt = 1'b1;
    #4;
    vectors++;
    if (o_m1_gnt !== 1'b1 || o_m0_gnt !== 1'b0 || o_s_addr !== A1) begin
      miscompares++; $display("FAIL lock_first got=%b%b addr=%h exp=01 addr=%h", o_m0_gnt, o_m1_gnt, o_s_addr, A1);
    end
    if (o_m1_gnt === 1'b1) sb_q.push_back(1'b1);
    next_cycle();
    i_m1_req = 1'b0;
    #4;
    vectors++;
    if (o_m0_gnt !== 1'b1 || o_s_addr !== A0) begin
      miscompares++; $display("FAIL lock_second got=%b addr=%h exp=1 addr=%h", o_m0_gnt, o_s_addr, A0);
    end
    if (o_m0_gnt === 1'b1) sb_q.push_back(1'b0);
    next_cycle();
    i_m0_req = 1'b0; i_s_gnt = 1'b0; i_s_rsp = 1'b1;
    for (int r = 0; r < 2; r++) begin
      i_s_rdata = 32'hC0DE_0000 + r;
      #4;
      exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
      vectors++;
      if (o_m0_rsp !== !exp_owner || o_m1_rsp !== exp_owner || o_s_rdy !== 1'b1) begin
        miscompares++; $display("FAIL lock_rsp[%0d] got=%b%b rdy=%b exp=%b%b rdy=1", r,
                                o_m0_rsp, o_m1_rsp, o_s_rdy, !exp_owner, exp_owner);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_full();
    bit exp_owner;
    i_m0_req = 1'b1; i_s_gnt = 1'b1;
    #4;
    if (o_m0_gnt === 1'b1) sb_q.push_back(1'b0);
    next_cycle();
    i_m0_req = 1'b0; i_m1_req = 1'b1;
    #4;
    if (o_m1_gnt === 1'b1) sb_q.push_back(1'b1);
    next_cycle();
    i_m1_req = 1'b0; i_m0_req = 1'b1;
    #4;
    vectors++;
    if (o_s_req !== 1'b0 || o_m0_gnt !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++; $display("FAIL full_block got req=%b gnt=%b busy=%b exp req=0 gnt=0 busy=1",
                              o_s_req, o_m0_gnt, o_busy);
    end
    next_cycle();
    // pop in the same cycle: still no new request while full
    i_s_rsp = 1'b1; i_m0_rdy = 1'b1;
    #4;
    exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b1;
    vectors++;
    if (o_s_req !== 1'b0 || o_m0_rsp !== !exp_owner || o_s_rdy !== 1'b1) begin
      miscompares++; $display("FAIL full_pop got req=%b rsp0=%b rdy=%b exp req=0 rsp0=%b rdy=1",
                              o_s_req, o_m0_rsp, o_s_rdy, !exp_owner);
    end
    next_cycle();
    i_s_rsp = 1'b0;
    #4;
    vectors++;
    if (o_s_req !== 1'b1 || o_m0_gnt !== 1'b1) begin
      miscompares++; $display("FAIL full_resume got req=%b gnt=%b exp req=1 gnt=1", o_s_req, o_m0_gnt);
    end
    if (o_m0_gnt === 1'b1) sb_q.push_back(1'b0);
    next_cycle();
    i_m0_req = 1'b0; i_s_gnt = 1'b0; i_s_rsp = 1'b1;
    for (int r = 0; r < 2; r++) begin
      #4;
      exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
      vectors++;
      if (o_m0_rsp !== !exp_owner || o_m1_rsp !== exp_owner) begin
        miscompares++; $display("FAIL full_drain[%0d] got=%b%b exp=%b%b", r, o_m0_rsp, o_m1_rsp,
                                !exp_owner, exp_owner);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_backpressure();
    bit exp_owner;
    i_m0_req = 1'b1; i_s_gnt = 1'b1;
    #4;
    if (o_m0_gnt === 1'b1) sb_q.push_back(1'b0);
    next_cycle();
    i_m0_req = 1'b0; i_m1_req = 1'b1;
    #4;
    if (o_m1_gnt === 1'b1) sb_q.push_back(1'b1);
    next_cycle();
    i_m1_req = 1'b0; i_s_gnt = 1'b0;
    i_s_rsp = 1'b1; i_s_rdata = 32'h1234_5678; i_m0_rdy = 1'b0; i_m1_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      vectors++;
      if (o_s_rdy !== 1'b0 || o_m0_rsp !== 1'b1 || o_m1_rsp !== 1'b0) begin
        miscompares++; $display("FAIL bp_stall[%0d] got rdy=%b rsp=%b%b exp rdy=0 rsp=10", c,
                                o_s_rdy, o_m0_rsp, o_m1_rsp);
      end
      next_cycle();
    end
    i_m0_rdy = 1'b1;
    #4;
    exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b1;
    vectors++;
    if (o_s_rdy !== 1'b1 || o_m0_rsp !== !exp_owner || o_m0_rdata !== 32'h1234_5678) begin
      miscompares++; $display("FAIL bp_release got rdy=%b rsp0=%b data=%h exp rdy=1 rsp0=%b data=12345678",
                              o_s_rdy, o_m0_rsp, o_m0_rdata, !exp_owner);
    end
    next_cycle();
    i_s_rdata = 32'h8765_4321;
    #4;
    exp_owner = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
    vectors++;
    if (o_m1_rsp !== exp_owner || o_m0_rsp !== !exp_owner || o_m1_rdata !== 32'h8765_4321) begin
      miscompares++; $display("FAIL bp_next got=%b%b data=%h exp=%b%b data=87654321",
                              o_m0_rsp, o_m1_rsp, o_m1_rdata, !exp_owner, exp_owner);
    end
    next_cycle();
    idle();
    #4;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++; $display("FAIL bp_empty got=%b exp=0", o_busy);
    end
    next_cycle();
  endtask

  task automatic test_err_reset();
    i_s_rsp = 1'b1;
    #4;
    vectors++;
    if (o_err !== 1'b1 || o_m0_rsp !== 1'b0 || o_m1_rsp !== 1'b0 || o_s_rdy !== 1'b0) begin
      miscompares++; $display("FAIL err_pulse got err=%b rsp=%b%b rdy=%b exp err=1 rsp=00 rdy=0",
                              o_err, o_m0_rsp, o_m1_rsp, o_s_rdy);
    end
    next_cycle();
    i_s_rsp = 1'b0;
    #4;
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++; $display("FAIL err_clear got=%b exp=0", o_err);
    end
    next_cycle();
    i_m0_req = 1'b1; i_s_gnt = 1'b1;
    next_cycle();
    i_m0_req = 1'b0; i_m1_req = 1'b1;
    next_cycle();
    // two outstanding; reset while requests and a response are presented
    i_rst = 1'b1; i_m0_req = 1'b1; i_s_rsp = 1'b1;
    #4;
    vectors++;
    if ({o_s_req, o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp, o_s_rdy, o_err, o_busy} !== 8'h00) begin
      miscompares++; $display("FAIL rst_mid got=%b exp=%b",
                              {o_s_req, o_m0_gnt, o_m1_gnt, o_m0_rsp, o_m1_rsp, o_s_rdy, o_err, o_busy}, 8'h00);
    end
    next_cycle();
    sb_q.delete();
    i_rst = 1'b0; i_m0_req = 1'b0; i_m1_req = 1'b0; i_s_gnt = 1'b0;
    #4;
    vectors++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_m0_rsp !== 1'b0 || o_m1_rsp !== 1'b0) begin
      miscompares++; $display("FAIL rst_dropped got err=%b busy=%b rsp=%b%b exp err=1 busy=0 rsp=00",
                              o_err, o_busy, o_m0_rsp, o_m1_rsp);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  initial begin
    i_m0_addr = A0; i_m0_wrcs = 1'b1; i_m0_mask = 4'hF; i_m0_wdata = 32'h1111_0000;
    i_m1_addr = A1; i_m1_wrcs = 1'b0; i_m1_mask = 4'h3; i_m1_wdata = 32'h2222_0000;
    idle();
    i_rst = 1'b1;
    #1;
    test_reset();
    test_single();
    test_arbitration();
    test_lock();
    test_full();
    test_backpressure();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
